// File: rtl/te_packet_decoder.sv
// te_packet_decoder: reassembles length-framed trace packets and decodes format and standard fields.
// Define TE_DECODE_DIFF_ADDR_EN to rebuild branch/address-only addresses from a last-address register.
module te_packet_decoder #(
  parameter int XLEN = 32,
  parameter int PRIVLEN = 2,
  parameter int CAUSELEN = 5,
  parameter int MAX_BYTES = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic in_valid_i,
  output logic in_ready_o,
  input  logic [7:0] in_data_i,
  output logic pkt_valid_o,
  input  logic pkt_ready_i,
  output logic [1:0] pkt_format_o,
  output logic [1:0] pkt_subformat_o,
  output logic pkt_branch_o,
  output logic [PRIVLEN-1:0] pkt_priv_o,
  output logic [CAUSELEN-1:0] pkt_ecause_o,
  output logic pkt_interrupt_o,
  output logic [4:0] pkt_branches_o,
  output logic [30:0] pkt_branch_map_o,
  output logic [XLEN-1:0] pkt_addr_o,
  output logic [$clog2(MAX_BYTES+1)-1:0] pkt_len_o,
  output logic [MAX_BYTES*8-1:0] pkt_payload_o,
  output logic err_o
);
  localparam int LW = $clog2(MAX_BYTES + 1);
  localparam logic [7:0] MAXB = 8'(MAX_BYTES);
  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD, OUTPUT} state_e;
  state_e state, state_n;
  logic [MAX_BYTES*8-1:0] payload;
  logic [LW-1:0] len, idx;
  logic [7:0] rem;
  logic [1:0] fmt, sub;
  logic take, last, len_ok, is_br, is_ad, is_sync, is_trap;
  logic [XLEN-1:0] diff, rel_addr;
  assign take = in_valid_i & in_ready_o;
  assign last = rem == 8'd1;
  assign len_ok = in_data_i != 8'd0 && in_data_i <= MAXB;
  assign idx = len - LW'(rem);
  assign fmt = payload[1:0];
  assign sub = fmt == 2'd3 ? payload[3:2] : 2'd0;
  assign is_br = fmt == 2'd1;
  assign is_ad = fmt == 2'd2;
  assign is_sync = fmt == 2'd3 && sub == 2'd0;
  assign is_trap = fmt == 2'd3 && sub == 2'd1;
  assign diff = is_br ? XLEN'(payload >> 38) : XLEN'(payload >> 2);
  always_ff @(posedge clk_i)
    if (!rst_ni) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take && in_data_i != 8'd0) state_n = in_data_i > MAXB ? DISCARD : COLLECT;
      COLLECT: if (take && last) state_n = OUTPUT;
      DISCARD: if (take && last) state_n = IDLE;
      OUTPUT:  if (pkt_ready_i) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    in_ready_o = rst_ni && state != OUTPUT;
    pkt_valid_o = state == OUTPUT;
  end
  // rem counts bytes still owed by the current frame, for both collect and discard
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      payload <= '0;
      len <= '0;
      rem <= '0;
      err_o <= 1'b0;
    end else begin
      err_o <= state == IDLE && take && !len_ok;
      if (state == IDLE && take) begin
        rem <= in_data_i;
        if (len_ok) begin
          payload <= '0;
          len <= LW'(in_data_i);
        end
      end else if (take) begin
        rem <= rem - 8'd1;
        if (state == COLLECT) payload[{idx, 3'b000} +: 8] <= in_data_i;
      end
    end
  end
`ifdef TE_DECODE_DIFF_ADDR_EN
  logic [XLEN-1:0] last_addr;
  assign rel_addr = last_addr + diff;
  always_ff @(posedge clk_i)
    if (!rst_ni) last_addr <= '0;
    else if (pkt_valid_o && pkt_ready_i && (is_br || is_ad || is_sync || is_trap)) last_addr <= pkt_addr_o;
`else
  assign rel_addr = diff;
`endif
  always_comb begin
    pkt_format_o = fmt;
    pkt_subformat_o = sub;
    pkt_len_o = len;
    pkt_payload_o = payload;
    pkt_branches_o = is_br ? 5'(payload >> 2) : 5'd0;
    pkt_branch_map_o = is_br ? 31'(payload >> 7) : 31'd0;
    pkt_branch_o = (is_sync | is_trap) & payload[4];
    pkt_priv_o = is_sync | is_trap ? PRIVLEN'(payload >> 5) : '0;
    pkt_ecause_o = is_trap ? CAUSELEN'(payload >> (5 + PRIVLEN)) : '0;
    pkt_interrupt_o = is_trap & payload[5+PRIVLEN+CAUSELEN];
    pkt_addr_o = is_sync ? XLEN'(payload >> (5 + PRIVLEN)) :
                 is_trap ? XLEN'(payload >> (6 + PRIVLEN + CAUSELEN)) :
                 is_br | is_ad ? rel_addr : '0;
  end
endmodule

// File: tb/tb_te_packet_decoder.sv
// tb_te_packet_decoder: directed and randomized checks of te_packet_decoder against a bit-layout reference model.
module tb_te_packet_decoder;
  logic clk_i = 0, rst_ni = 0, in_valid_i = 0, pkt_ready_i = 0;
  logic [7:0] in_data_i = 0;
  logic in_ready_o, pkt_valid_o, pkt_branch_o, pkt_interrupt_o, err_o;
  logic [1:0] pkt_format_o, pkt_subformat_o, pkt_priv_o;
  logic [4:0] pkt_ecause_o, pkt_branches_o, pkt_len_o;
  logic [30:0] pkt_branch_map_o;
  logic [31:0] pkt_addr_o;
  logic [127:0] pkt_payload_o;
  int total = 0, bad = 0, cyc = 0;
  bit gaps = 0;
  logic [31:0] last_addr = 0;
  typedef struct packed {
    logic [1:0] fmt, sub;
    logic branch;
    logic [1:0] priv;
    logic [4:0] ecause;
    logic intr;
    logic [4:0] branches;
    logic [30:0] map;
    logic [31:0] addr;
    logic [4:0] len;
    logic [127:0] payload;
  } pkt_t;

  te_packet_decoder #(.XLEN(32), .PRIVLEN(2), .CAUSELEN(5), .MAX_BYTES(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .pkt_valid_o(pkt_valid_o), .pkt_ready_i(pkt_ready_i),
    .pkt_format_o(pkt_format_o), .pkt_subformat_o(pkt_subformat_o), .pkt_branch_o(pkt_branch_o),
    .pkt_priv_o(pkt_priv_o), .pkt_ecause_o(pkt_ecause_o), .pkt_interrupt_o(pkt_interrupt_o),
    .pkt_branches_o(pkt_branches_o), .pkt_branch_map_o(pkt_branch_map_o), .pkt_addr_o(pkt_addr_o),
    .pkt_len_o(pkt_len_o), .pkt_payload_o(pkt_payload_o), .err_o(err_o));

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic pkt_t observed();
    return {pkt_format_o, pkt_subformat_o, pkt_branch_o, pkt_priv_o, pkt_ecause_o, pkt_interrupt_o,
            pkt_branches_o, pkt_branch_map_o, pkt_addr_o, pkt_len_o, pkt_payload_o};
  endfunction

  function automatic logic [31:0] rel(input logic [31:0] last, input logic [31:0] d);
`ifdef TE_DECODE_DIFF_ADDR_EN
    return last + d;
`else
    return d;
`endif
  endfunction

  function automatic pkt_t model(input logic [127:0] v, input int len, input logic [31:0] last);
    pkt_t e;
    e = '0;
    e.fmt = v[1:0];
    e.len = 5'(len);
    e.payload = v;
    case (e.fmt)
      2'd1: begin e.branches = v[6:2]; e.map = v[37:7]; e.addr = rel(last, v[69:38]); end
      2'd2: e.addr = rel(last, v[33:2]);
      2'd3: begin
        e.sub = v[3:2];
        if (e.sub == 2'd0) begin e.branch = v[4]; e.priv = v[6:5]; e.addr = v[38:7]; end
        if (e.sub == 2'd1) begin
          e.branch = v[4]; e.priv = v[6:5]; e.ecause = v[11:7]; e.intr = v[12]; e.addr = v[44:13];
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    logic r;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid_i = 0;
      @(posedge clk_i); #1;
    end
    in_valid_i = 1;
    in_data_i = b;
    do begin
      r = in_ready_o;
      @(posedge clk_i); #1;
      n++;
    end while (!r && n < 50);
    if (!r) begin
      total++; bad++;
      $display("FAIL send_byte timeout in_ready=%b required=1", in_ready_o);
    end
  endtask

  task automatic send_pkt(input logic [127:0] v, input int len);
    send_byte(8'(len));
    for (int k = 0; k < len; k++) send_byte(v[8*k +: 8]);
    in_valid_i = 0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!pkt_valid_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (!pkt_valid_o) begin
      total++; bad++;
      $display("FAIL wait_valid timeout pkt_valid=%b required=1", pkt_valid_o);
    end
  endtask

  task automatic take_pkt(input pkt_t e);
    pkt_ready_i = 1;
    @(posedge clk_i); #1;
    pkt_ready_i = 0;
    if (e.fmt == 2'd1 || e.fmt == 2'd2 || (e.fmt == 2'd3 && e.sub < 2'd2)) last_addr = e.addr;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    repeat (3) @(posedge clk_i);
    #1;
    total++;
    if ({pkt_valid_o, err_o, in_ready_o, observed()} !== '0) begin
      bad++; $display("FAIL reset_state got=%h required=0", {pkt_valid_o, err_o, in_ready_o, observed()});
    end
    rst_ni = 1;
    last_addr = 0;
    @(posedge clk_i); #1;
    total++;
    if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_release in_ready=%b required=1", in_ready_o); end
  endtask

  task automatic test_sync();
    logic [127:0] v = 128'h40_0000_0073;
    pkt_t e = model(v, 5, last_addr);
    int c0 = cyc;
    send_byte(8'd5);
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8]);
    total++;
    if (pkt_valid_o !== 1'b0) begin bad++; $display("FAIL sync_early pkt_valid=%b required=0", pkt_valid_o); end
    send_byte(v[39:32]);
    in_valid_i = 0;
    total++;
    if (pkt_valid_o !== 1'b1 || cyc - c0 != 6) begin
      bad++; $display("FAIL sync_latency pkt_valid=%b cycles=%0d required 1 at 6", pkt_valid_o, cyc - c0);
    end
    total++;
    if ({pkt_format_o, pkt_subformat_o, pkt_branch_o, pkt_priv_o, pkt_addr_o, pkt_len_o} !==
        {2'd3, 2'd0, 1'b1, 2'd3, 32'h8000_0000, 5'd5}) begin
      bad++; $display("FAIL sync_fields got fmt=%0d sub=%0d br=%b priv=%0d addr=%h len=%0d required 3 0 1 3 80000000 5",
                      pkt_format_o, pkt_subformat_o, pkt_branch_o, pkt_priv_o, pkt_addr_o, pkt_len_o);
    end
    total++;
    if (observed() !== e) begin bad++; $display("FAIL sync_model got=%h required=%h", observed(), e); end
    take_pkt(e);
    total++;
    if (pkt_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL sync_handshake valid=%b ready=%b required 0 1", pkt_valid_o, in_ready_o);
    end
  endtask

  task automatic test_diff();
    logic [127:0] v = 128'h42;
    pkt_t e = model(v, 5, last_addr);
    logic [31:0] want;
`ifdef TE_DECODE_DIFF_ADDR_EN
    want = 32'h8000_0010;
`else
    want = 32'h0000_0010;
`endif
    send_pkt(v, 5);
    wait_valid();
    total++;
    if (pkt_format_o !== 2'd2 || pkt_addr_o !== want) begin
      bad++; $display("FAIL diff_addr fmt=%0d addr=%h required 2 %h", pkt_format_o, pkt_addr_o, want);
    end
    total++;
    if (observed() !== e) begin bad++; $display("FAIL diff_model got=%h required=%h", observed(), e); end
    take_pkt(e);
  endtask

  task automatic test_wrap();
    logic [127:0] s = (128'hFFFF_FFF0 << 7) | 128'h3;
    logic [127:0] d = 128'h82;
    pkt_t e = model(s, 5, last_addr);
    logic [31:0] want;
`ifdef TE_DECODE_DIFF_ADDR_EN
    want = 32'h0000_0010;
`else
    want = 32'h0000_0020;
`endif
    send_pkt(s, 5);
    wait_valid();
    total++;
    if (pkt_addr_o !== 32'hFFFF_FFF0) begin bad++; $display("FAIL wrap_sync addr=%h required=fffffff0", pkt_addr_o); end
    take_pkt(e);
    e = model(d, 5, last_addr);
    send_pkt(d, 5);
    wait_valid();
    total++;
    if (pkt_addr_o !== want || observed() !== e) begin
      bad++; $display("FAIL wrap_addr addr=%h required=%h", pkt_addr_o, want);
    end
    take_pkt(e);
  endtask

  task automatic test_oversize();
    int c0 = cyc;
    bit seen = 0;
    send_byte(8'h11);
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL oversize_err err=%b required=1", err_o); end
    for (int k = 0; k < 17; k++) begin
      send_byte(8'($urandom));
      if (k == 0) begin
        total++;
        if (err_o !== 1'b0) begin bad++; $display("FAIL oversize_pulse err=%b required=0", err_o); end
      end
      seen |= pkt_valid_o;
    end
    in_valid_i = 0;
    repeat (3) begin @(posedge clk_i); #1; seen |= pkt_valid_o; end
    total++;
    if (seen || cyc - c0 != 21) begin
      bad++; $display("FAIL oversize_drop valid_seen=%b cycles=%0d required 0 21", seen, cyc - c0);
    end
  endtask

  task automatic test_zero_len();
    send_byte(8'd0);
    in_valid_i = 0;
    total++;
    if (err_o !== 1'b1) begin bad++; $display("FAIL zero_err err=%b required=1", err_o); end
    @(posedge clk_i); #1;
    total++;
    if (err_o !== 1'b0 || pkt_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL zero_after err=%b valid=%b ready=%b required 0 0 1", err_o, pkt_valid_o, in_ready_o);
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] v = 128'h40_0000_0073;
    pkt_t e = model(v, 5, last_addr);
    send_pkt(v, 5);
    wait_valid();
    in_valid_i = 1;
    in_data_i = 8'h05;
    repeat (3) begin
      @(posedge clk_i); #1;
      total++;
      if (in_ready_o !== 1'b0 || pkt_valid_o !== 1'b1 || observed() !== e) begin
        bad++; $display("FAIL bp_hold ready=%b valid=%b got=%h required 0 1 %h", in_ready_o, pkt_valid_o, observed(), e);
      end
    end
    in_valid_i = 0;
    take_pkt(e);
    total++;
    if (pkt_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      bad++; $display("FAIL bp_release valid=%b ready=%b required 0 1", pkt_valid_o, in_ready_o);
    end
    v = 128'h42;
    e = model(v, 5, last_addr);
    send_pkt(v, 5);
    wait_valid();
    total++;
    if (observed() !== e) begin bad++; $display("FAIL bp_next got=%h required=%h", observed(), e); end
    take_pkt(e);
  endtask

  task automatic test_reset_mid();
    logic [127:0] v = 128'h42;
    pkt_t e;
    send_byte(8'd5);
    send_byte(8'h73);
    send_byte(8'h00);
    in_valid_i = 0;
    rst_ni = 0;
    last_addr = 0;
    @(posedge clk_i); #1;
    total++;
    if ({pkt_valid_o, err_o, in_ready_o, observed()} !== '0) begin
      bad++; $display("FAIL reset_mid_state got=%h required=0", {pkt_valid_o, err_o, in_ready_o, observed()});
    end
    @(posedge clk_i); #1;
    rst_ni = 1;
    @(posedge clk_i); #1;
    total++;
    if (err_o !== 1'b0 || pkt_valid_o !== 1'b0) begin
      bad++; $display("FAIL reset_mid_quiet err=%b valid=%b required 0 0", err_o, pkt_valid_o);
    end
    e = model(v, 5, last_addr);
    send_pkt(v, 5);
    wait_valid();
    total++;
    if (observed() !== e) begin bad++; $display("FAIL reset_mid_diff got=%h required=%h", observed(), e); end
    take_pkt(e);
    v = 128'h40_0000_0073;
    e = model(v, 5, last_addr);
    send_pkt(v, 5);
    wait_valid();
    total++;
    if (observed() !== e) begin bad++; $display("FAIL reset_mid_sync got=%h required=%h", observed(), e); end
    take_pkt(e);
  endtask

  task automatic test_random();
    gaps = 1;
    for (int i = 0; i < 60; i++) begin
      int kind = $urandom_range(0, 9);
      int len = kind == 0 ? 0 : kind == 1 ? $urandom_range(17, 24) : $urandom_range(1, 16);
      logic [127:0] v = {$urandom, $urandom, $urandom, $urandom};
      pkt_t e;
      bit seen = 0;
      if (len < 16) v &= (128'(1) << (8 * len)) - 128'(1);
      if (len == 0 || len > 16) begin
        send_byte(8'(len));
        total++;
        if (err_o !== 1'b1) begin bad++; $display("FAIL rand_err[%0d] len=%0d err=%b required=1", i, len, err_o); end
        for (int k = 0; k < len; k++) begin send_byte(8'($urandom)); seen |= pkt_valid_o; end
        in_valid_i = 0;
        @(posedge clk_i); #1;
        seen |= pkt_valid_o;
        total++;
        if (seen) begin bad++; $display("FAIL rand_drop[%0d] len=%0d valid_seen=1 required=0", i, len); end
      end else begin
        e = model(v, len, last_addr);
        send_pkt(v, len);
        total++;
        if (pkt_valid_o !== 1'b1 || observed() !== e) begin
          bad++; $display("FAIL rand_pkt[%0d] valid=%b got=%h required=%h", i, pkt_valid_o, observed(), e);
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        total++;
        if (pkt_valid_o !== 1'b1 || observed() !== e) begin
          bad++; $display("FAIL rand_hold[%0d] valid=%b got=%h required=%h", i, pkt_valid_o, observed(), e);
        end
        take_pkt(e);
      end
    end
    gaps = 0;
  endtask

  initial begin
    test_reset();
    test_sync();
    test_diff();
    test_wrap();
    test_oversize();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
